psx_pad_responder: RTL and testbench

- Controller-side counterpart of the PSX host poller: consumes att/psx_clk/cmd and produces data/ack.
- Emulates a digital pad (ID 0x41) answering the 5-byte 0x01/0x42 poll.
- Used as the closed-loop partner of the host block on the bench, and as a pad stand-in on hardware.
- Button state comes from a 16-bit active-low input. Each received command byte is also reported on a strobe interface.

---
 rtl/psx_pad_responder.sv | 212 +++++++++++++++++++++
 tb/tb_psx_pad_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_pad_responder.sv
// PSX digital pad responder.
// Answers the host's 5-byte 0x01/0x42 poll as a digital pad (ID PAD_ID),
// driving data/ack back toward the host and reporting every received
// command byte on a one-cycle strobe. All host lines are asynchronous and
// are brought into the clk domain through 2-flop synchronizers.
module psx_pad_responder #(
  parameter int unsigned ACK_DELAY = 24,
  parameter int unsigned ACK_WIDTH = 4,
  parameter logic [7:0]  PAD_ID    = 8'h41
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACK_WAIT,
    ST_ACK_PULSE,
    ST_IGNORE
  } state_t;

  // Synchronizer stages plus one history flop per line for edge detection.
  // Idle-high lines reset to 1 so that leaving reset never looks like an edge.
  logic att_meta_q, att_sync_q, att_prev_q;
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic cmd_meta_q, cmd_sync_q;

  state_t      state_q;
  logic        data_q;
  logic        ack_q;
  logic [7:0]  cmd_byte_q;
  logic        cmd_valid_q;
  logic [15:0] snap_q;
  logic [7:0]  shift_q;
  logic [3:0]  bit_cnt_q;
  logic [2:0]  byte_idx_q;
  logic [31:0] delay_q;

  logic       psx_fall, psx_rise, att_fall, att_rise;
  logic [7:0] reply_byte_d;
  logic       reply_bit_d;
  logic [7:0] cmd_byte_d;
  logic       bad_header_d;

  // Two-flop synchronizers and previous-value flops for all host inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      att_meta_q <= 1'b1;
      att_sync_q <= 1'b1;
      att_prev_q <= 1'b1;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      cmd_meta_q <= 1'b1;
      cmd_sync_q <= 1'b1;
    end else begin
      att_meta_q <= att;
      att_sync_q <= att_meta_q;
      att_prev_q <= att_sync_q;
      clk_meta_q <= psx_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      cmd_meta_q <= cmd;
      cmd_sync_q <= cmd_meta_q;
    end
  end

  assign psx_fall = clk_prev_q & ~clk_sync_q;
  assign psx_rise = ~clk_prev_q & clk_sync_q;
  assign att_fall = att_prev_q & ~att_sync_q;
  assign att_rise = ~att_prev_q & att_sync_q;

  // Reply byte for the current position in the poll, and the command byte
  // as it will look once the bit arriving on this rise is merged in.
  always_comb begin
    reply_byte_d = 8'hFF;
    unique case (byte_idx_q)
      3'd0:    reply_byte_d = 8'hFF;
      3'd1:    reply_byte_d = PAD_ID;
      3'd2:    reply_byte_d = 8'h5A;
      3'd3:    reply_byte_d = snap_q[7:0];
      default: reply_byte_d = snap_q[15:8];
    endcase
    cmd_byte_d = shift_q;
    cmd_byte_d[bit_cnt_q[2:0]] = cmd_sync_q;
    bad_header_d = ((byte_idx_q == 3'd0) && (cmd_byte_d != 8'h01)) ||
                   ((byte_idx_q == 3'd1) && (cmd_byte_d != 8'h42)) ||
                   (byte_idx_q == 3'd4);
  end

  assign reply_bit_d = reply_byte_d[bit_cnt_q[2:0]];

  // Protocol FSM: shifts reply bits out on psx_clk falls, collects command
  // bits on rises, and times the ack pulse after each accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= 1'b1;
      ack_q       <= 1'b1;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      snap_q      <= 16'h0000;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 4'd0;
      byte_idx_q  <= 3'd0;
      delay_q     <= 32'd0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (att_rise) begin
        // Host ended the transaction: abandon any partial byte or pending ack.
        state_q    <= ST_IDLE;
        data_q     <= 1'b1;
        ack_q      <= 1'b1;
        shift_q    <= 8'h00;
        bit_cnt_q  <= 4'd0;
        byte_idx_q <= 3'd0;
        delay_q    <= 32'd0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            data_q <= 1'b1;
            ack_q  <= 1'b1;
            if (att_fall) begin
              snap_q     <= buttons;
              shift_q    <= 8'h00;
              bit_cnt_q  <= 4'd0;
              byte_idx_q <= 3'd0;
              delay_q    <= 32'd0;
              state_q    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (psx_fall) begin
              data_q <= reply_bit_d;
            end else if (psx_rise) begin
              if (bit_cnt_q == 4'd7) begin
                cmd_byte_q  <= cmd_byte_d;
                cmd_valid_q <= 1'b1;
                shift_q     <= 8'h00;
                bit_cnt_q   <= 4'd0;
                data_q      <= 1'b1;
                if (bad_header_d) begin
                  state_q <= ST_IGNORE;
                end else begin
                  byte_idx_q <= byte_idx_q + 3'd1;
                  delay_q    <= 32'd0;
                  state_q    <= ST_ACK_WAIT;
                end
              end else begin
                shift_q[bit_cnt_q[2:0]] <= cmd_sync_q;
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ST_ACK_WAIT: begin
            if (psx_fall) begin
              // Host did not wait for the ack; follow it straight away.
              data_q  <= reply_bit_d;
              ack_q   <= 1'b1;
              delay_q <= 32'd0;
              state_q <= ST_SHIFT;
            end else if (delay_q == ACK_DELAY - 32'd1) begin
              ack_q   <= 1'b0;
              delay_q <= 32'd0;
              state_q <= ST_ACK_PULSE;
            end else begin
              delay_q <= delay_q + 32'd1;
            end
          end
          ST_ACK_PULSE: begin
            if (psx_fall) begin
              data_q  <= reply_bit_d;
              ack_q   <= 1'b1;
              delay_q <= 32'd0;
              state_q <= ST_SHIFT;
            end else if (delay_q == ACK_WIDTH - 32'd1) begin
              ack_q   <= 1'b1;
              delay_q <= 32'd0;
              state_q <= ST_SHIFT;
            end else begin
              delay_q <= delay_q + 32'd1;
            end
          end
          ST_IGNORE: begin
            data_q <= 1'b1;
            ack_q  <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            data_q  <= 1'b1;
            ack_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign data      = data_q;
  assign ack       = ack_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Bench for psx_pad_responder: acts as the PSX host, drives polls with
// randomized commands, buttons and bit timing, and checks replies, ack
// timing and command strobes against a byte-level protocol model.
`timescale 1ns/1ps
module tb_psx_pad_responder;

  localparam int unsigned ACK_DELAY = 24;
  localparam int unsigned ACK_WIDTH = 4;
  localparam logic [7:0]  PAD_ID    = 8'h41;
  // Host-visible latency of the 2-flop synchronizer plus edge detect.
  localparam int          SYNC_LAT  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        att = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic [15:0] buttons = 16'hFFFF;
  logic        data, ack, cmd_valid;
  logic [7:0]  cmd_byte;

  int          n_checks = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic        prev_cv = 1'b0;

  always #5 clk = ~clk;

  psx_pad_responder #(
    .ACK_DELAY(ACK_DELAY),
    .ACK_WIDTH(ACK_WIDTH),
    .PAD_ID(PAD_ID)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .att(att),
    .psx_clk(psx_clk),
    .cmd(cmd),
    .buttons(buttons),
    .data(data),
    .ack(ack),
    .cmd_byte(cmd_byte),
    .cmd_valid(cmd_valid)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Pad reply table: what the host must read back for each byte position.
  function automatic logic [7:0] model_reply(input int idx, input logic [15:0] s);
    case (idx)
      0:       return 8'hFF;
      1:       return PAD_ID;
      2:       return 8'h5A;
      3:       return s[7:0];
      default: return s[15:8];
    endcase
  endfunction

  // Command strobe checker: each strobe must be single-cycle and carry the
  // next byte the model says the pad has fully received.
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      check("cmd_valid_width", {63'd0, prev_cv}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_cmd_valid: got strobe with cmd_byte %0h, required none", cmd_byte);
      end else begin
        check("cmd_byte", cmd_byte, exp_q.pop_front());
      end
    end
    prev_cv = cmd_valid & rst_n;
  end

  // One host poll. abort_byte/abort_bit raise att before that bit;
  // rst_byte pulses rst_n during the ack pulse following that byte.
  task automatic do_poll(input logic [39:0] cmds, input logic [15:0] btn,
                         input logic [15:0] btn_after, input int h,
                         input int abort_byte, input int abort_bit, input int rst_byte,
                         output logic [39:0] got, output int acks);
    logic [15:0] snap;
    logic        alive, aborted, ack_exp;
    logic [7:0]  cv, rx, ev;
    int          n, w, bad;
    got = '1;
    acks = 0;
    aborted = 1'b0;
    alive = 1'b1;
    buttons = btn;
    @(negedge clk);
    att = 1'b0;
    snap = btn;
    repeat (6) @(negedge clk);
    buttons = btn_after;
    for (int b = 0; b < 5; b++) begin
      cv = cmds[8*b +: 8];
      ev = alive ? model_reply(b, snap) : 8'hFF;
      rx = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (b == abort_byte && i == abort_bit) begin
          att = 1'b1;
          repeat (SYNC_LAT) @(negedge clk);
          check("abort_data", {63'd0, data}, 64'd1);
          check("abort_ack", {63'd0, ack}, 64'd1);
          aborted = 1'b1;
          break;
        end
        psx_clk = 1'b0;
        cmd = cv[i];
        repeat (h) @(negedge clk);
        rx[i] = data;
        if (i == 7 && alive) exp_q.push_back(cv);
        psx_clk = 1'b1;
        if (i != 7) repeat (h) @(negedge clk);
      end
      if (aborted) break;
      got[8*b +: 8] = rx;
      check("data_byte", {56'd0, rx}, {56'd0, ev});
      ack_exp = 1'b0;
      if (alive) begin
        if ((b == 0 && cv != 8'h01) || (b == 1 && cv != 8'h42)) alive = 1'b0;
        else if (b < 4) ack_exp = 1'b1;
      end
      if (ack_exp) begin
        n = 0;
        bad = 0;
        do begin
          @(negedge clk);
          n++;
          if (n > SYNC_LAT && data !== 1'b1) bad++;
        end while (ack !== 1'b0 && n < 200);
        check("ack_delay", 64'(n), 64'(SYNC_LAT + ACK_DELAY));
        check("data_high_after_byte", 64'(bad), 64'd0);
        if (b == rst_byte) begin
          @(negedge clk);
          #2 rst_n = 1'b0;
          #1;
          check("rst_ack", {63'd0, ack}, 64'd1);
          check("rst_data", {63'd0, data}, 64'd1);
          check("rst_cmd_byte", {56'd0, cmd_byte}, 64'd0);
          check("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
          check("strobes_before_rst", 64'(exp_q.size()), 64'd0);
          exp_q.delete();
          att = 1'b1;
          psx_clk = 1'b1;
          cmd = 1'b1;
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          aborted = 1'b1;
          break;
        end
        w = 0;
        while (ack === 1'b0 && w < 100) begin
          w++;
          @(negedge clk);
        end
        check("ack_width", 64'(w), 64'(ACK_WIDTH));
        acks++;
      end else begin
        bad = 0;
        for (int k = 1; k <= int'(ACK_DELAY + ACK_WIDTH) + 8; k++) begin
          @(negedge clk);
          if (ack !== 1'b1) bad++;
          if (k > SYNC_LAT && data !== 1'b1) bad++;
        end
        check("no_ack_data_high", 64'(bad), 64'd0);
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
    end
    if (!aborted) att = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_data", {63'd0, data}, 64'd1);
    check("idle_ack", {63'd0, ack}, 64'd1);
    check("strobes_seen", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    logic [39:0] got;
    logic [39:0] cmds;
    logic [7:0]  c;
    int          acks, kind, ab, abit;

    #1 rst_n = 1'b0;
    #2;
    check("reset_data", {63'd0, data}, 64'd1);
    check("reset_ack", {63'd0, ack}, 64'd1);
    check("reset_cmd_byte", {56'd0, cmd_byte}, 64'd0);
    check("reset_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Standard poll with only the lowest button pressed.
    do_poll(40'h0000004201, 16'hFFFE, 16'hFFFE, 6, -1, 0, -1, got, acks);
    check("full_poll_bytes", {24'd0, got}, {24'd0, 40'hFFFE5A41FF});
    check("full_poll_acks", 64'(acks), 64'd4);
    $display("poll full: data=%010h acks=%0d", got, acks);

    // Wrong start byte: no acks at all, then a normal poll.
    do_poll(40'h0000004281, 16'h1234, 16'h1234, 5, -1, 0, -1, got, acks);
    check("bad_start_acks", 64'(acks), 64'd0);
    $display("poll bad_start: data=%010h acks=%0d", got, acks);
    do_poll(40'h0000004201, 16'hA55A, 16'hA55A, 4, -1, 0, -1, got, acks);
    check("after_bad_start_bytes", {24'd0, got}, {24'd0, 40'hA55A5A41FF});
    $display("poll recover: data=%010h acks=%0d", got, acks);

    // att raised three bits into byte 2, then a full poll.
    do_poll(40'h0000004201, 16'h00FF, 16'h00FF, 6, 2, 3, -1, got, acks);
    check("abort_acks", 64'(acks), 64'd2);
    $display("poll abort: data=%010h acks=%0d", got, acks);
    do_poll(40'h0000004201, 16'h8001, 16'h8001, 6, -1, 0, -1, got, acks);
    $display("poll after_abort: data=%010h acks=%0d", got, acks);

    // Buttons change after att falls: snapshot must hold.
    do_poll(40'h0000004201, 16'hFFFE, 16'h0000, 6, -1, 0, -1, got, acks);
    check("snapshot_bytes", {48'd0, got[39:24]}, {48'd0, 16'hFFFE});
    $display("poll snapshot: data=%010h acks=%0d", got, acks);
    do_poll(40'h0000004201, 16'h0000, 16'h0000, 6, -1, 0, -1, got, acks);
    check("next_snapshot_bytes", {48'd0, got[39:24]}, 64'd0);
    $display("poll snapshot_next: data=%010h acks=%0d", got, acks);

    // Reset asserted during the ack pulse after byte 1.
    do_poll(40'h0000004201, 16'h5555, 16'h5555, 6, -1, 0, 1, got, acks);
    $display("poll reset_in_ack: acks=%0d", acks);
    do_poll(40'h0000004201, 16'h3C3C, 16'h3C3C, 5, -1, 0, -1, got, acks);
    check("after_reset_bytes", {24'd0, got}, {24'd0, 40'h3C3C5A41FF});
    $display("poll after_reset: data=%010h acks=%0d", got, acks);

    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 5));
      cmds = {8'($urandom), 8'($urandom), 8'($urandom), 8'h42, 8'h01};
      ab = -1;
      abit = 0;
      if (kind == 3) begin
        c = 8'($urandom);
        if (c == 8'h01) c = 8'h81;
        cmds[7:0] = c;
      end else if (kind == 4) begin
        c = 8'($urandom);
        if (c == 8'h42) c = 8'h43;
        cmds[15:8] = c;
      end else if (kind == 5) begin
        ab = int'($urandom_range(0, 4));
        abit = int'($urandom_range(1, 7));
      end
      do_poll(cmds, 16'($urandom), 16'($urandom), int'($urandom_range(4, 8)), ab, abit, -1, got, acks);
      $display("poll rand %0d kind=%0d cmds=%010h data=%010h acks=%0d", t, kind, cmds, got, acks);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
